// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector of a small combinational block, captures its outputs and counts ones
module truth_table_sweeper #(
    parameter int N_IN        = 6,
    parameter int N_OUT       = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [N_OUT-1:0]          dut_out,
    output logic [N_IN-1:0]           vec_out,
    output logic                      busy,
    output logic                      done,
    output logic                      res_we,
    output logic [N_IN-1:0]           res_addr,
    output logic [N_OUT-1:0]          res_data,
    output logic [N_OUT*(N_IN+1)-1:0] ones_cnt
);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int CW = N_IN + 1;
    state_t        state, state_nx;
    logic [HW-1:0] hold_cnt;
    logic          sample;
    logic          last;
    // sampling edge ends a hold window unless abort cancels it; next-state selection
    always_comb begin
        sample   = state == DRIVE && hold_cnt == HW'(HOLD_CYCLES - 1) && !abort;
        last     = vec_out == '1;
        state_nx = IDLE;
        if (state == IDLE)
            state_nx = start ? DRIVE : IDLE;
        else if (state == DRIVE)
            state_nx = abort ? IDLE : (sample && last) ? DONE : DRIVE;
    end
    // state, vector/hold counters, result capture and per-output ones counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec_out  <= '0;
            hold_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_we   <= 1'b0;
            res_addr <= '0;
            res_data <= '0;
            ones_cnt <= '0;
        end else begin
            state  <= state_nx;
            busy   <= state_nx == DRIVE;
            done   <= state_nx == DONE;
            res_we <= sample;
            if (state == IDLE && start) begin
                ones_cnt <= '0;
                hold_cnt <= '0;
                vec_out  <= '0;
            end else if (state == DRIVE) begin
                if (abort) begin
                    vec_out  <= '0;
                    hold_cnt <= '0;
                end else if (sample) begin
                    hold_cnt <= '0;
                    res_data <= dut_out;
                    res_addr <= vec_out;
                    vec_out  <= last ? '0 : vec_out + N_IN'(1);
                    for (int j = 0; j < N_OUT; j++)
                        ones_cnt[j*CW +: CW] <= ones_cnt[j*CW +: CW] + CW'(dut_out[j]);
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: checks sweeps with HOLD_CYCLES 1 and 3 against a truth-table reference model
module tb_truth_table_sweeper;
    logic        clk = 0, rst_n = 1;
    logic        start1 = 0, start3 = 0, abort1 = 0, abort3 = 0;
    logic [63:0] tbl_x, tbl_y;
    logic [5:0]  vec1, vec3, addr1, addr3;
    logic        busy1, busy3, done1, done3, we1, we3;
    logic [1:0]  data1, data3, dout1, dout3;
    logic [13:0] ones1, ones3;
    logic        busy_a [2], done_a [2], we_a [2];
    logic [5:0]  vec_a [2], addr_a [2];
    logic [1:0]  data_a [2];
    logic [13:0] ones_a [2];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign dout1 = {tbl_x[vec1], tbl_y[vec1]};
    assign dout3 = {tbl_x[vec3], tbl_y[vec3]};
    assign busy_a[0] = busy1;  assign busy_a[1] = busy3;
    assign done_a[0] = done1;  assign done_a[1] = done3;
    assign we_a[0]   = we1;    assign we_a[1]   = we3;
    assign vec_a[0]  = vec1;   assign vec_a[1]  = vec3;
    assign addr_a[0] = addr1;  assign addr_a[1] = addr3;
    assign data_a[0] = data1;  assign data_a[1] = data3;
    assign ones_a[0] = ones1;  assign ones_a[1] = ones3;

    truth_table_sweeper #(.N_IN(6), .N_OUT(2), .HOLD_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_out(dout1),
        .vec_out(vec1), .busy(busy1), .done(done1), .res_we(we1),
        .res_addr(addr1), .res_data(data1), .ones_cnt(ones1));

    truth_table_sweeper #(.N_IN(6), .N_OUT(2), .HOLD_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .dut_out(dout3),
        .vec_out(vec3), .busy(busy3), .done(done3), .res_we(we3),
        .res_addr(addr3), .res_data(data3), .ones_cnt(ones3));

    task automatic set_tables(input int mode);
        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            tbl_x[i] = mode == 0 ? (v[5] & v[4]) : mode == 1 ? 1'($urandom) : 1'b1;
            tbl_y[i] = mode == 0 ? ^v : mode == 1 ? 1'($urandom) : 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy_a[d], done_a[d], we_a[d], vec_a[d], addr_a[d], data_a[d], ones_a[d]} !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: busy=%b done=%b we=%b vec=%h addr=%h data=%b ones=%h, required all zero",
                         d, busy_a[d], done_a[d], we_a[d], vec_a[d], addr_a[d], data_a[d], ones_a[d]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_sweep(input int mode);
        set_tables(mode);
        @(negedge clk);
        start1 = 1; start3 = 1;
        @(posedge clk);
        #1 start1 = 0; start3 = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int h, a;
                logic b_e, d_e, w_e;
                logic [5:0] v_e;
                h   = d ? 3 : 1;
                b_e = k < 64 * h;
                d_e = k == 64 * h;
                w_e = k >= h && k <= 64 * h && k % h == 0;
                v_e = k < 64 * h ? 6'(k / h) : 6'd0;
                a   = k / h - 1;
                checks++;
                if ({busy_a[d], done_a[d], we_a[d], vec_a[d]} !== {b_e, d_e, w_e, v_e}) begin
                    errors++;
                    $display("FAIL sweep h=%0d k=%0d: busy/done/we/vec=%b/%b/%b/%h, required %b/%b/%b/%h",
                             h, k, busy_a[d], done_a[d], we_a[d], vec_a[d], b_e, d_e, w_e, v_e);
                end
                if (w_e) begin
                    checks++;
                    if ({addr_a[d], data_a[d]} !== {6'(a), tbl_x[a], tbl_y[a]}) begin
                        errors++;
                        $display("FAIL result h=%0d k=%0d: addr=%h data=%b, required addr=%h data=%b",
                                 h, k, addr_a[d], data_a[d], 6'(a), {tbl_x[a], tbl_y[a]});
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ones_a[d] !== {7'($countones(tbl_x)), 7'($countones(tbl_y))}) begin
                errors++;
                $display("FAIL ones[%0d]: got %0d/%0d, required %0d/%0d", d, ones_a[d][13:7], ones_a[d][6:0],
                         $countones(tbl_x), $countones(tbl_y));
            end
        end
    endtask

    task automatic test_abort();
        int n_we = 0, sx = 0, sy = 0;
        bit found = 0;
        set_tables(1);
        @(negedge clk);
        start1 = 1;
        @(posedge clk);
        #1 start1 = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (we1) n_we++;
            if (we1 && addr1 == 6'd9) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_wait: result for addr 9 not seen, required within 100 cycles");
        end
        abort1 = 1;
        @(negedge clk);
        abort1 = 0;
        checks++;
        if ({busy1, vec1, we1} !== 8'd0) begin
            errors++;
            $display("FAIL abort_next: busy=%b vec=%h we=%b, required 0/00/0", busy1, vec1, we1);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (we1) n_we++;
            checks++;
            if (done1 !== 1'b0) begin
                errors++;
                $display("FAIL abort_done k=%0d: done=%b, required 0", k, done1);
            end
        end
        checks++;
        if (n_we != 10) begin
            errors++;
            $display("FAIL abort_count: res_we pulses=%0d, required 10", n_we);
        end
        for (int i = 0; i < 10; i++) begin
            sx += int'(tbl_x[i]);
            sy += int'(tbl_y[i]);
        end
        checks++;
        if (ones1 !== {7'(sx), 7'(sy)}) begin
            errors++;
            $display("FAIL abort_ones: got %0d/%0d, required %0d/%0d", ones1[13:7], ones1[6:0], sx, sy);
        end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        set_tables(1);
        @(negedge clk);
        start1 = 1;
        @(posedge clk);
        #1 start1 = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (vec1 == 6'h25) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL areset_wait: vec_out 0x25 not seen, required within 100 cycles");
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({busy1, done1, we1, vec1, addr1, data1, ones1} !== '0) begin
            errors++;
            $display("FAIL areset: busy=%b done=%b we=%b vec=%h addr=%h data=%b ones=%h, required all zero",
                     busy1, done1, we1, vec1, addr1, data1, ones1);
        end
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({busy1, done1, vec1} !== 8'd0) begin
                errors++;
                $display("FAIL areset_idle k=%0d: busy=%b done=%b vec=%h, required 0/0/00", k, busy1, done1, vec1);
            end
        end
    endtask

    task automatic test_start_held();
        int n_done = 0, busy_bad = 0;
        set_tables(0);
        @(negedge clk);
        start1 = 1;
        @(posedge clk);
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (done1) n_done++;
            if (k < 64 && !busy1) busy_bad++;
            if (k == 65) begin
                checks++;
                if ({busy1, done1, ones1} !== {2'b00, 7'd16, 7'd32}) begin
                    errors++;
                    $display("FAIL held_idle: busy=%b done=%b ones=%0d/%0d, required 0/0 16/32",
                             busy1, done1, ones1[13:7], ones1[6:0]);
                end
            end
            if (k == 66) begin
                checks++;
                if ({busy1, ones1} !== 15'h4000) begin
                    errors++;
                    $display("FAIL held_restart: busy=%b ones=%h, required busy=1 ones=0", busy1, ones1);
                end
            end
        end
        checks++;
        if (n_done != 1 || busy_bad != 0) begin
            errors++;
            $display("FAIL held_first: done pulses=%0d busy drops=%0d, required 1 and 0", n_done, busy_bad);
        end
        start1 = 0;
        abort1 = 1;
        @(negedge clk);
        abort1 = 0;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL held_stop: busy=%b, required 0", busy1);
        end
    endtask

    task automatic test_final_abort();
        bit found = 0;
        set_tables(2);
        @(negedge clk);
        start1 = 1;
        @(posedge clk);
        #1 start1 = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (vec1 == 6'd63) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL final_wait: vec_out 63 not seen, required within 100 cycles");
        end
        abort1 = 1;
        @(negedge clk);
        abort1 = 0;
        checks++;
        if ({we1, busy1, done1, vec1, ones1} !== {9'd0, 7'd63, 7'd63}) begin
            errors++;
            $display("FAIL final_abort: we=%b busy=%b done=%b vec=%h ones=%0d/%0d, required 0/0/0/00 63/63",
                     we1, busy1, done1, vec1, ones1[13:7], ones1[6:0]);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({done1, we1} !== 2'b00) begin
                errors++;
                $display("FAIL final_quiet k=%0d: done=%b we=%b, required 0/0", k, done1, we1);
            end
        end
    endtask

    initial begin
        tbl_x = '0;
        tbl_y = '0;
        test_reset();
        test_sweep(0);
        test_sweep(1);
        test_abort();
        test_async_reset();
        test_start_held();
        test_final_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Upstream stimulus and capture stage for small combinational blocks, such as the six-input/two-output logic stages in the guide exercises.
- Drives every input combination in ascending binary order, holding each for a programmable number of cycles.
- Samples the DUT outputs at the end of each hold window and streams one result word per vector.
- Accumulates a ones-count per output, so on-board checks need no testbench.

Parameters:
N_IN, 6, number of DUT inputs; sweep covers 2^N_IN vectors.
N_OUT, 2, number of DUT outputs sampled.
HOLD_CYCLES, 1, clock cycles each vector is held (>=1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin sweep; sampled in IDLE only.
abort  input  1  synchronous cancel of a running sweep.
dut_out  input  N_OUT  DUT outputs; bit N_OUT-1 = first output (x).
vec_out  output  N_IN  vector driven to DUT; bit N_IN-1 = first input (a).
busy  output  1  high in DRIVE state.
done  output  1  one-cycle pulse after the last vector is sampled.
res_we  output  1  one-cycle strobe, result word valid.
res_addr  output  N_IN  vector the result belongs to.
res_data  output  N_OUT  sampled dut_out.
ones_cnt  output  N_OUT*(N_IN+1)  per-output count of 1 samples; output j occupies slice [j*(N_IN+1) +: N_IN+1].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - vec_out, res_addr, res_data, ones_cnt, and the hold counter = 0.
  - busy=done=res_we=0.
  - Takes effect immediately and overrides any state, including mid-sweep.
- States: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE:
  - vec_out=0, busy=0.
  - start=1 at an edge -> DRIVE. At that edge: ones_cnt cleared, hold counter=0, vec_out=0.
  - abort is ignored in IDLE.
- DRIVE:
  - busy=1.
  - The hold counter increments each edge from 0 to HOLD_CYCLES-1.
  - At the edge where the hold counter equals HOLD_CYCLES-1:
    - res_data<=dut_out, res_addr<=vec_out, res_we<=1.
    - Each ones_cnt slice increments by the corresponding dut_out bit.
    - Hold counter <= 0.
    - If vec_out = 2^N_IN-1: state<=DONE and vec_out<=0. Otherwise vec_out<=vec_out+1.
  - res_we is 0 on every other edge.
  - dut_out is sampled HOLD_CYCLES cycles after vec_out changes; the DUT must settle within one cycle.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then -> IDLE unconditionally.
  - start during DONE is ignored.
  - res_we for the final vector (from the transition edge) is high in the DONE cycle.
- abort=1 in DRIVE:
  - At the next edge: state<=IDLE, vec_out<=0, hold counter<=0, res_we<=0, no done pulse.
  - ones_cnt keeps its partial value.
  - If abort coincides with a sampling edge, abort wins: no result is written for that vector and ones_cnt is not updated.
- start while busy=1 has no effect.
- ones_cnt never wraps: the maximum is 2^N_IN and the width is N_IN+1.
- Sweep length: start edge to DONE entry = 2^N_IN*HOLD_CYCLES edges.
- Exactly 2^N_IN res_we pulses per complete sweep, with res_addr ascending 0..2^N_IN-1.

Test Plan:
1. Defaults, dut_out={a&b, ^vec_out}, start pulsed at edge E0:
   - busy high E0..E64.
   - 64 res_we pulses with res_addr 0..63.
   - done in the single cycle after E64.
   - ones_cnt slice1=16, slice0=32.
2. HOLD_CYCLES=3, same DUT model:
   - res_we pulses spaced exactly 3 cycles apart.
   - DONE is entered 192 edges after start.
   - Counts are 16/32 as in scenario 1.
   - vec_out changes only on sampling edges.
3. Abort after the result for res_addr=9 is written:
   - Next edge: busy=0, vec_out=0.
   - No done pulse.
   - 10 res_we pulses total.
   - ones_cnt reflects vectors 0..9 only.
4. rst_n driven low asynchronously mid-sweep (vec_out=0x25):
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release, the block stays IDLE until start.
5. start held high continuously:
   - A second sweep begins on the first edge after done drops (the edge leaving IDLE).
   - ones_cnt is cleared at that edge.
   - No extra sweep is started during DRIVE or DONE.
6. dut_out tied to 2'b11 with abort asserted on the final sampling edge:
   - No res_we for vector 63.
   - No done pulse.
   - ones_cnt = 63/63.
